add6_sched: RTL
===============

Name: add6_sched

Overview:
- Sequencing controller for the six-lane bias-add/ReLU accumulation stage that follows the six parallel convolution channels.
- Watches the occupancy counts of the six lane FIFOs and issues one lockstep read strobe across all lanes.
- Tracks column, row and map position so it can flag which sums are kept and which bias entry applies.
- Signals per-map and per-frame completion to the layer sequencer.

Parameters:
- LANES, 6, number of input lanes / FIFOs read in lockstep
- CW, 4, width of each lane occupancy count
- ROW_LEN, 9, sums per output row; column 0 of each row is discarded
- ROWS, 9, rows per output map
- NUM_MAPS, 16, output maps per frame
- BIAS_AW, 4, bias address width (2^BIAS_AW >= NUM_MAPS)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a frame; ignored unless idle
- ds_ready  in  1  downstream can accept a sum this cycle
- lane_cnt  in  LANES*CW  packed FIFO occupancy counts; lane k is bits [k*CW+CW-1 : k*CW]
- rd_en  out  1  registered broadcast read strobe to all lane FIFOs
- rd_vld  out  1  rd_en delayed one cycle; FIFO outputs are valid and the sum is formed this cycle
- out_keep  out  1  qualifies rd_vld; low for column-0 results
- bias_addr  out  BIAS_AW  index of the current map's bias word
- busy  out  1  high from the cycle after an accepted start until the cycle frame_done is asserted
- map_done  out  1  one-cycle pulse after a map's last rd_vld
- frame_done  out  1  one-cycle pulse after the last map completes

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; rd_en=0, rd_vld=0, out_keep=0, bias_addr=0, busy=0, map_done=0, frame_done=0; col/row/map counters cleared. Reset mid-frame abandons the frame; nothing resumes.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN; busy=1 next cycle; counters=0.
  - start in any other state is ignored.
- RUN, issue rule: next rd_en=1 iff all of the following hold:
  - ds_ready=1;
  - every lane_cnt > (rd_en ? 1 : 0). FIFO counts lag a read by one cycle, so back-to-back reads need >=2 entries per lane.
  - fewer than ROW_LEN*ROWS reads issued for the current map.
- RUN, counting:
  - Each issued read advances col; col wraps ROW_LEN-1 -> 0 and increments row.
  - Each read's col value is pipelined alongside rd_vld.
  - out_keep = rd_vld && (pipelined col != 0).
  - After the map's last read (row=ROWS-1, col=ROW_LEN-1) is issued -> DRAIN.
- DRAIN:
  - No reads are issued.
  - The cycle the final rd_vld is high: map_done=1 next cycle and bias_addr increments.
  - If the map was not the last, return to RUN with col=row=0.
  - If map=NUM_MAPS-1, go to DONE.
- DONE:
  - frame_done=1 and busy=0 for one cycle; bias_addr returns to 0.
  - Next state IDLE.
- bias_addr is stable for every rd_vld belonging to a map. The increment never coincides with a rd_vld of the same map.
- Latency: condition true at edge N -> rd_en high in cycle N+1 -> rd_vld/out_keep high in cycle N+2.
- ds_ready low suppresses new reads only; an in-flight rd_vld still completes.
- Per map: exactly ROW_LEN*ROWS rd_vld pulses, of which ROWS*(ROW_LEN-1) carry out_keep=1. Defaults: 81 and 72.
- Lane imbalance: any lane at 0 (or 1 while rd_en=1) blocks all lanes, so no lane is ever read empty.

Test Plan:
- Reset then start with all lane_cnt=15 and ds_ready=1 -> rd_en continuous for 81 cycles; 81 rd_vld, 72 with out_keep; map_done 2 cycles after the last rd_en; bias_addr 0->1.
- All lane_cnt held at 1, rd_en already high -> next rd_en=0 (no underflow); a single read resumes when the counts refresh.
- Lane 3 cnt=0 while others =5 -> rd_en stays 0 until lane 3 >=1; no partial-lane reads.
- ds_ready toggling 1,0,1,0 -> rd_en follows with one-cycle lag; total keep count per map still 72; col sequence unbroken.
- Full frame of 16 maps -> 16 map_done pulses, bias_addr 0..15, a single frame_done, busy low afterwards; a start pulse mid-frame has no effect.
- reset_n low in the middle of map 5 -> all outputs 0 immediately (asynchronous); a following start restarts at map 0, col 0.

Source files
------------

// File: rtl/add6_sched.sv
// Lockstep read sequencer for the six-lane bias-add/ReLU stage: issues FIFO reads,
// tracks column/row/map position and reports map and frame completion.
module add6_sched #(
  parameter int LANES    = 6,
  parameter int CW       = 4,
  parameter int ROW_LEN  = 9,
  parameter int ROWS     = 9,
  parameter int NUM_MAPS = 16,
  parameter int BIAS_AW  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  ds_ready,
  input  logic [LANES*CW-1:0]   lane_cnt,
  output logic                  rd_en,
  output logic                  rd_vld,
  output logic                  out_keep,
  output logic [BIAS_AW-1:0]    bias_addr,
  output logic                  busy,
  output logic                  map_done,
  output logic                  frame_done
);

  localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [BIAS_AW-1:0] MAP_LAST = BIAS_AW'(NUM_MAPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   rd_col_q, rd_col_d;
  logic [BIAS_AW-1:0] bias_q, bias_d;
  logic               rd_en_q, rd_en_d;
  logic               rd_vld_q, rd_vld_d;
  logic               keep_q, keep_d;
  logic               busy_q, busy_d;
  logic               map_done_q, map_done_d;
  logic               frame_done_q, frame_done_d;
  logic               lanes_ok;
  logic               issue;

  // A read already in flight is not yet reflected in the counts, so it needs one spare entry.
  always_comb begin
    lanes_ok = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      if (lane_cnt[k*CW +: CW] <= CW'(rd_en_q)) lanes_ok = 1'b0;
    end
  end

  assign issue = (state_q == RUN) && ds_ready && lanes_ok;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    bias_d       = bias_q;
    busy_d       = busy_q;
    map_done_d   = 1'b0;
    frame_done_d = 1'b0;
    rd_en_d      = issue;
    rd_vld_d     = rd_en_q;
    rd_col_d     = col_q;
    keep_d       = rd_en_q && (rd_col_q != '0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
          bias_d  = '0;
        end
      end
      RUN: begin
        if (issue) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Nothing is issued here, so rd_vld without rd_en marks the map's final sum.
        if (rd_vld_q && !rd_en_q) begin
          map_done_d = 1'b1;
          bias_d     = bias_q + 1'b1;
          state_d    = (bias_q == MAP_LAST) ? DONE : RUN;
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        bias_d       = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      rd_col_q     <= '0;
      bias_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_vld_q     <= 1'b0;
      keep_q       <= 1'b0;
      busy_q       <= 1'b0;
      map_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      rd_col_q     <= rd_col_d;
      bias_q       <= bias_d;
      rd_en_q      <= rd_en_d;
      rd_vld_q     <= rd_vld_d;
      keep_q       <= keep_d;
      busy_q       <= busy_d;
      map_done_q   <= map_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_vld     = rd_vld_q;
  assign out_keep   = keep_q;
  assign bias_addr  = bias_q;
  assign busy       = busy_q;
  assign map_done   = map_done_q;
  assign frame_done = frame_done_q;

endmodule
